// File: rtl/picorv32_axi_adapter_v2.sv
// picorv32_axi_adapter_v2: bridges the PicoRV32 native memory bus to an AXI4-lite master, one transaction in flight
//
// Optional feature: define AXI_ADAPTER_TIMEOUT_EN to enable the bus watchdog limited by TIMEOUT_CYCLES.
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   mem_axi_aw*_o/_i, mem_axi_w*_o/_i   AXI4-lite write address and write data channels
//   mem_axi_b*_o/_i                     AXI4-lite write response channel
//   mem_axi_ar*_o/_i, mem_axi_r*_o/_i   AXI4-lite read address and read data channels
//   mem_valid_i, mem_instr_i            native request and fetch flag (request held until mem_ready_o)
//   mem_addr_i, mem_wdata_i, mem_wstrb_i request address, write data, byte enables (all zero = read)
//   mem_ready_o, mem_rdata_o, mem_error_o one-cycle completion, registered read data, error flag
module picorv32_axi_adapter_v2 #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter bit PROT_PRIV      = 1'b0,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int STRB_W        = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic              mem_axi_awvalid_o,
   input  logic              mem_axi_awready_i,
   output logic [ADDR_W-1:0] mem_axi_awaddr_o,
   output logic [2:0]        mem_axi_awprot_o,
   output logic              mem_axi_wvalid_o,
   input  logic              mem_axi_wready_i,
   output logic [DATA_W-1:0] mem_axi_wdata_o,
   output logic [STRB_W-1:0] mem_axi_wstrb_o,
   input  logic              mem_axi_bvalid_i,
   output logic              mem_axi_bready_o,
   input  logic [1:0]        mem_axi_bresp_i,
   output logic              mem_axi_arvalid_o,
   input  logic              mem_axi_arready_i,
   output logic [ADDR_W-1:0] mem_axi_araddr_o,
   output logic [2:0]        mem_axi_arprot_o,
   input  logic              mem_axi_rvalid_i,
   output logic              mem_axi_rready_o,
   input  logic [1:0]        mem_axi_rresp_i,
   input  logic [DATA_W-1:0] mem_axi_rdata_i,
   input  logic              mem_valid_i,
   input  logic              mem_instr_i,
   output logic              mem_ready_o,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [STRB_W-1:0] mem_wstrb_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_error_o
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("picorv32_axi_adapter_v2: DATA_W must be 32/64 and TIMEOUT_CYCLES 1..65535");
   end

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              instr_q, instr_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              unused_resp;
`ifdef AXI_ADAPTER_TIMEOUT_EN
   logic [15:0]       cnt_q, cnt_d;
`endif

   // Only resp[1] distinguishes failure; OKAY and EXOKAY are both success.
   assign unused_resp = mem_axi_bresp_i[0] ^ mem_axi_rresp_i[0];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      instr_d   = instr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: if (mem_valid_i) begin
            addr_d    = mem_addr_i;
            wdata_d   = mem_wdata_i;
            wstrb_d   = mem_wstrb_i;
            instr_d   = mem_instr_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = |mem_wstrb_i ? S_WR_REQ : S_RD_REQ;
         end
         S_WR_REQ: begin
            // AW and W complete independently; both may land on the same edge.
            aw_done_d = aw_done_q | mem_axi_awready_i;
            w_done_d  = w_done_q | mem_axi_wready_i;
            state_d   = (aw_done_d && w_done_d) ? S_WR_RESP : S_WR_REQ;
         end
         S_WR_RESP: if (mem_axi_bvalid_i) begin
            state_d = S_DONE;
            err_d   = mem_axi_bresp_i[1];
         end
         S_RD_REQ: state_d = mem_axi_arready_i ? S_RD_RESP : S_RD_REQ;
         S_RD_RESP: if (mem_axi_rvalid_i) begin
            state_d = S_DONE;
            rdata_d = mem_axi_rdata_i;
            err_d   = mem_axi_rresp_i[1];
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef AXI_ADAPTER_TIMEOUT_EN
      cnt_d = (state_q == S_IDLE) ? 16'd0 : (state_q == S_DONE) ? cnt_q : cnt_q + 16'd1;
      // The watchdog overrides any handshake completing on the same edge.
      if (state_q != S_IDLE && state_q != S_DONE && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
         state_d = S_DONE;
         rdata_d = rdata_q;
         err_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         instr_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef AXI_ADAPTER_TIMEOUT_EN
         cnt_q     <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         instr_q   <= instr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
`ifdef AXI_ADAPTER_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Valid/ready outputs derive from state alone, so reset or timeout drops them on the next edge.
   assign mem_axi_awvalid_o = (state_q == S_WR_REQ) && !aw_done_q;
   assign mem_axi_wvalid_o  = (state_q == S_WR_REQ) && !w_done_q;
   assign mem_axi_bready_o  = (state_q == S_WR_RESP);
   assign mem_axi_arvalid_o = (state_q == S_RD_REQ);
   assign mem_axi_rready_o  = (state_q == S_RD_RESP);
   assign mem_axi_awaddr_o  = addr_q;
   assign mem_axi_araddr_o  = addr_q;
   assign mem_axi_awprot_o  = {instr_q, 1'b0, PROT_PRIV};
   assign mem_axi_arprot_o  = {instr_q, 1'b0, PROT_PRIV};
   assign mem_axi_wdata_o   = wdata_q;
   assign mem_axi_wstrb_o   = wstrb_q;
   assign mem_ready_o       = (state_q == S_DONE);
   assign mem_rdata_o       = rdata_q;
   assign mem_error_o       = err_q;
endmodule

// File: tb/tb_picorv32_axi_adapter_v2.sv
// tb_picorv32_axi_adapter_v2: timeline-model checking of the PicoRV32 to AXI4-lite adapter
module tb_picorv32_axi_adapter_v2;
`ifdef AXI_ADAPTER_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif
   logic clk = 1'b0, reset = 1'b1;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb, mem_wstrb;
   logic [1:0] bresp, rresp;
   logic mem_valid, mem_instr, mem_ready, mem_error;

   picorv32_axi_adapter_v2 #(.ADDR_W(32), .DATA_W(32), .PROT_PRIV(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .reset_i(reset),
      .mem_axi_awvalid_o(awvalid), .mem_axi_awready_i(awready), .mem_axi_awaddr_o(awaddr), .mem_axi_awprot_o(awprot),
      .mem_axi_wvalid_o(wvalid), .mem_axi_wready_i(wready), .mem_axi_wdata_o(wdata), .mem_axi_wstrb_o(wstrb),
      .mem_axi_bvalid_i(bvalid), .mem_axi_bready_o(bready), .mem_axi_bresp_i(bresp),
      .mem_axi_arvalid_o(arvalid), .mem_axi_arready_i(arready), .mem_axi_araddr_o(araddr), .mem_axi_arprot_o(arprot),
      .mem_axi_rvalid_i(rvalid), .mem_axi_rready_o(rready), .mem_axi_rresp_i(rresp), .mem_axi_rdata_i(rdata),
      .mem_valid_i(mem_valid), .mem_instr_i(mem_instr), .mem_ready_o(mem_ready), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb), .mem_rdata_o(mem_rdata), .mem_error_o(mem_error)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0;
   // Current transaction: request presented at cycle c0, slave waits d1/d2/d3, completion at cycle done.
   bit act = 0, wr = 0, ins = 0, tmo_t = 0, drop = 0;
   int c0 = 0, d1 = 0, d2 = 0, d3 = 0, done = 0;
   logic [1:0] resp = 2'b00;
   logic [31:0] t_addr = 0, t_wdata = 0, t_rdata = 0, m_rdata = 0;
   logic [3:0] t_wstrb = 0;
   // Observations gathered by the compare process for the literal checks.
   int ready_cnt = 0, ar_cnt = 0, last_aw = 0, last_w = 0, last_rdy = 0;
   logic last_err = 0;
   logic [2:0] last_arprot = 0;
   bit prev_ar = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
      end
   endtask

   function automatic int maxi(input int a, input int b);
      return a > b ? a : b;
   endfunction

   // Slave and core behaviour for the current cycle.
   task automatic drive();
      mem_valid = act && cyc <= done && !(drop && cyc >= c0 + 2);
      mem_instr = ins;
      mem_addr  = t_addr;
      mem_wdata = t_wdata;
      mem_wstrb = wr ? t_wstrb : 4'b0000;
      awready   = act && wr && cyc >= c0 + 1 + d1 && cyc < done;
      wready    = act && wr && cyc >= c0 + 1 + d2 && cyc < done;
      bvalid    = act && wr && cyc >= c0 + 2 + maxi(d1, d2) + d3 && cyc < done;
      arready   = act && !wr && cyc >= c0 + 1 + d1 && cyc < done;
      rvalid    = act && !wr && cyc >= c0 + 2 + d1 + d2 && cyc < done;
      bresp     = resp;
      rresp     = resp;
      rdata     = t_rdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (act && !wr && !tmo_t && cyc == done) m_rdata = t_rdata;
      drive();
   endtask

   task automatic start(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input bit fi, input int x1, input int x2, input int x3, input logic [1:0] rs,
                        input logic [31:0] rd, input bit dr);
      wr = w; t_addr = a; t_wdata = wd; t_wstrb = st; ins = fi; d1 = x1; d2 = x2; d3 = x3;
      resp = rs; t_rdata = rd; drop = dr; c0 = cyc; tmo_t = 0;
      done = w ? c0 + 3 + maxi(x1, x2) + x3 : c0 + 3 + x1 + x2;
`ifdef AXI_ADAPTER_TIMEOUT_EN
      if (done - 1 >= c0 + TMO) begin
         done = c0 + TMO + 1;
         tmo_t = 1;
      end
`endif
      act = 1;
      drive();
   endtask

   task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          input bit fi, input int x1, input int x2, input int x3, input logic [1:0] rs,
                          input logic [31:0] rd, input bit dr);
      start(w, a, wd, st, fi, x1, x2, x3, rs, rd, dr);
      while (cyc <= done) step();
      act = 0;
   endtask

   // Compare process: expected channel activity follows from the transaction's timeline.
   always @(negedge clk) begin
      int m;
      logic e_aw, e_w, e_b, e_ar, e_r, e_rdy;
      m     = maxi(d1, d2);
      e_aw  = act && wr && cyc >= c0 + 1 && cyc <= c0 + 1 + d1 && cyc < done;
      e_w   = act && wr && cyc >= c0 + 1 && cyc <= c0 + 1 + d2 && cyc < done;
      e_b   = act && wr && cyc >= c0 + 2 + m && cyc < done;
      e_ar  = act && !wr && cyc >= c0 + 1 && cyc <= c0 + 1 + d1 && cyc < done;
      e_r   = act && !wr && cyc >= c0 + 2 + d1 && cyc < done;
      e_rdy = act && cyc == done;
      chk("awvalid", awvalid, e_aw);
      chk("wvalid", wvalid, e_w);
      chk("bready", bready, e_b);
      chk("arvalid", arvalid, e_ar);
      chk("rready", rready, e_r);
      chk("mem_ready", mem_ready, e_rdy);
      chk("mem_rdata", mem_rdata, m_rdata);
      if (e_rdy) chk("mem_error", mem_error, tmo_t | resp[1]);
      if (e_aw) begin
         chk("awaddr", awaddr, t_addr);
         chk("awprot", awprot, {ins, 2'b01});
      end
      if (e_w) begin
         chk("wdata", wdata, t_wdata);
         chk("wstrb", wstrb, t_wstrb);
      end
      if (e_ar) begin
         chk("araddr", araddr, t_addr);
         chk("arprot", arprot, {ins, 2'b01});
      end
      if (awvalid) last_aw = cyc;
      if (wvalid) last_w = cyc;
      if (arvalid) last_arprot = arprot;
      if (arvalid && !prev_ar) ar_cnt++;
      prev_ar = arvalid;
      if (mem_ready) begin
         ready_cnt++;
         last_rdy = cyc;
         last_err = mem_error;
      end
   end

   initial begin
      int r0, a0;
      logic [31:0] keep;
      drive();
      repeat (3) step();
      chk("reset_rdata", mem_rdata, 32'h0);
      chk("reset_error", mem_error, 1'b0);
      reset = 0;
      step();
      // Zero-wait read.
      run_txn(0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 0);
      chk("rd_latency", last_rdy - c0, 3);
      chk("rd_data", mem_rdata, 32'hDEADBEEF);
      chk("rd_err", last_err, 1'b0);
      // Write, AW delayed two cycles, W immediate.
      r0 = ready_cnt;
      run_txn(1, 32'h200, 32'h11223344, 4'b0011, 0, 2, 0, 0, 2'b00, 32'h0, 0);
      chk("wr_w_last", last_w - c0, 1);
      chk("wr_aw_last", last_aw - c0, 3);
      chk("wr_pulses", ready_cnt - r0, 1);
      chk("wr_latency", last_rdy - c0, 5);
      chk("wr_zero_lat", 0, 0 + (last_rdy - c0 - 5));
      run_txn(1, 32'h204, 32'hA5A5A5A5, 4'b1111, 0, 0, 0, 0, 2'b00, 32'h0, 0);
      chk("wr0_latency", last_rdy - c0, 3);
      // SLVERR write then OKAY read.
      run_txn(1, 32'h300, 32'hCAFEF00D, 4'b1000, 0, 1, 3, 2, 2'b10, 32'h0, 0);
      chk("bresp_err", last_err, 1'b1);
      run_txn(0, 32'h304, 32'h0, 4'h0, 0, 1, 2, 0, 2'b00, 32'h12345678, 0);
      chk("rresp_ok", last_err, 1'b0);
      chk("rd2_data", mem_rdata, 32'h12345678);
      // EXOKAY success, DECERR failure.
      run_txn(0, 32'h308, 32'h0, 4'h0, 0, 0, 1, 0, 2'b01, 32'h0BADF00D, 0);
      chk("exokay", last_err, 1'b0);
      run_txn(0, 32'h30C, 32'h0, 4'h0, 0, 2, 0, 0, 2'b11, 32'h87654321, 0);
      chk("decerr", last_err, 1'b1);
      // Back-to-back instruction fetches.
      a0 = ar_cnt;
      run_txn(0, 32'h400, 32'h0, 4'h0, 1, 0, 0, 0, 2'b00, 32'h00000013, 0);
      run_txn(0, 32'h404, 32'h0, 4'h0, 1, 1, 0, 0, 2'b00, 32'h00000093, 0);
      chk("ar_count", ar_cnt - a0, 2);
      chk("arprot_fetch", last_arprot, 3'b101);
      // mem_valid withdrawn mid-write: transfer still completes.
      r0 = ready_cnt;
      run_txn(1, 32'h500, 32'h5555AAAA, 4'b0100, 0, 1, 2, 1, 2'b00, 32'h0, 1);
      chk("drop_pulses", ready_cnt - r0, 1);
      // Reset while in the read response phase.
      start(0, 32'h600, 32'h0, 4'h0, 0, 0, 5, 0, 2'b00, 32'hFFFF0000, 0);
      step();
      step();
      reset = 1;
      step();
      act = 0;
      reset = 0;
      m_rdata = 0;
      drive();
      chk("rst_rready", rready, 1'b0);
      chk("rst_ready", mem_ready, 1'b0);
      step();
      run_txn(0, 32'h700, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h77777777, 0);
      chk("post_rst_latency", last_rdy - c0, 3);
`ifdef AXI_ADAPTER_TIMEOUT_EN
      keep = mem_rdata;
      run_txn(0, 32'h800, 32'h0, 4'h0, 0, 50, 0, 0, 2'b00, 32'h99999999, 0);
      chk("tmo_latency", last_rdy - c0, 9);
      chk("tmo_err", last_err, 1'b1);
      chk("tmo_rdata", mem_rdata, keep);
`else
      keep = 32'h77777777;
      chk("hold_rdata", mem_rdata, keep);
`endif
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
